// File: rtl/y86_execute_stage_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, branch/cmov
// conditions, register "none" marker and the condition-code record.
package y86_execute_stage_pkg;

    localparam logic [3:0] I_HALT    = 4'h0;
    localparam logic [3:0] I_NOP     = 4'h1;
    localparam logic [3:0] I_RRMOVQ  = 4'h2;
    localparam logic [3:0] I_IRMOVQ  = 4'h3;
    localparam logic [3:0] I_RMMOVQ  = 4'h4;
    localparam logic [3:0] I_MRMOVQ  = 4'h5;
    localparam logic [3:0] I_OPQ     = 4'h6;
    localparam logic [3:0] I_JXX     = 4'h7;
    localparam logic [3:0] I_CALL    = 4'h8;
    localparam logic [3:0] I_RET     = 4'h9;
    localparam logic [3:0] I_PUSHQ   = 4'hA;
    localparam logic [3:0] I_POPQ    = 4'hB;

    localparam logic [3:0] A_ADD     = 4'h0;
    localparam logic [3:0] A_SUB     = 4'h1;
    localparam logic [3:0] A_AND     = 4'h2;
    localparam logic [3:0] A_XOR     = 4'h3;

    localparam logic [3:0] C_ALWAYS  = 4'h0;
    localparam logic [3:0] C_LE      = 4'h1;
    localparam logic [3:0] C_L       = 4'h2;
    localparam logic [3:0] C_E       = 4'h3;
    localparam logic [3:0] C_NE      = 4'h4;
    localparam logic [3:0] C_GE      = 4'h5;
    localparam logic [3:0] C_G       = 4'h6;

    localparam logic [3:0] RNONE     = 4'hF;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    // Branch / conditional-move predicate over the current condition codes.
    function automatic logic cond_eval(input logic [3:0] ifun, input cc_t cc);
        logic lt;
        lt = cc.sf ^ cc.of;
        case (ifun)
            C_ALWAYS: cond_eval = 1'b1;
            C_LE:     cond_eval = lt | cc.zf;
            C_L:      cond_eval = lt;
            C_E:      cond_eval = cc.zf;
            C_NE:     cond_eval = ~cc.zf;
            C_GE:     cond_eval = ~lt;
            C_G:      cond_eval = ~lt & ~cc.zf;
            default:  cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_execute_stage_if.sv
// Decode->execute (E register) and execute->memory (M register) bundle.
// The stage is the slave: it consumes E_* and produces M_*.
interface y86_execute_stage_if #(
    parameter int WIDTH = 64
);
    logic             E_valid;
    logic [3:0]       E_icode;
    logic [3:0]       E_ifun;
    logic [WIDTH-1:0] E_valA;
    logic [WIDTH-1:0] E_valB;
    logic [WIDTH-1:0] E_valC;
    logic [3:0]       E_dstE;
    logic [3:0]       E_dstM;

    logic             M_valid;
    logic [3:0]       M_icode;
    logic             M_cnd;
    logic [WIDTH-1:0] M_valE;
    logic [WIDTH-1:0] M_valA;
    logic [3:0]       M_dstE;
    logic [3:0]       M_dstM;

    modport master (
        output E_valid, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        input  M_valid, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  E_valid, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        output M_valid, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/adder_64.sv
// Two's-complement adder/subtractor with signed-overflow flag.
// sub_i=0: sum = a + b ; sub_i=1: sum = a - b (as a + ~b + 1).
module adder_64 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             of_o
);
    logic [WIDTH-1:0] b_eff;

    // Sum and overflow: operands of equal sign producing a result of the other sign.
    always_comb begin
        b_eff = b_i ^ {WIDTH{sub_i}};
        sum_o = a_i + b_eff + WIDTH'(sub_i);
        of_o  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
    end
endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: ALU operand selection, ALU, condition codes,
// jXX/cmovXX condition, forwarding outputs and the E->M pipeline register.
module y86_execute_stage
    import y86_execute_stage_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    y86_execute_stage_if.slave bus,
    input  logic              cc_inhibit,
    input  logic              M_stall,
    input  logic              M_bubble,
    output logic [WIDTH-1:0]  e_valE,
    output logic [3:0]        e_dstE,
    output logic              e_cnd,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alufun;
    logic [WIDTH-1:0] add_sum;
    logic             add_of;
    logic [WIDTH-1:0] val_e;
    logic             flag_of;
    logic             cc_we;
    logic             cnd;
    logic [3:0]       dst_e;

    cc_t cc_q, cc_d;

    logic             m_valid_q, m_valid_d;
    logic [3:0]       m_icode_q, m_icode_d;
    logic             m_cnd_q,   m_cnd_d;
    logic [WIDTH-1:0] m_vale_q,  m_vale_d;
    logic [WIDTH-1:0] m_vala_q,  m_vala_d;
    logic [3:0]       m_dste_q,  m_dste_d;
    logic [3:0]       m_dstm_q,  m_dstm_d;

    // ALU operand selection by instruction class; stack ops adjust rsp by 8.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (bus.E_icode)
            I_RRMOVQ, I_OPQ:              alu_a = bus.E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = bus.E_valC;
            I_CALL, I_PUSHQ:              alu_a = ~WIDTH'(7);
            I_RET, I_POPQ:                alu_a = WIDTH'(8);
            default:                      alu_a = '0;
        endcase
        case (bus.E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_RET, I_PUSHQ, I_POPQ:       alu_b = bus.E_valB;
            default:                      alu_b = '0;
        endcase
    end

    assign alufun = (bus.E_icode == I_OPQ) ? bus.E_ifun : A_ADD;

    adder_64 #(.WIDTH(WIDTH)) u_adder (
        .a_i   (alu_b),
        .b_i   (alu_a),
        .sub_i (alufun[0]),
        .sum_o (add_sum),
        .of_o  (add_of)
    );

    // ALU result; logic ops never overflow, undefined OPq functions yield zero.
    always_comb begin
        val_e   = '0;
        flag_of = 1'b0;
        case (alufun)
            A_ADD, A_SUB: begin
                val_e   = add_sum;
                flag_of = add_of;
            end
            A_AND:   val_e = alu_b & alu_a;
            A_XOR:   val_e = alu_b ^ alu_a;
            default: val_e = '0;
        endcase
    end

    // Condition-code write only for a real, defined OPq that is not blocked.
    always_comb begin
        cc_we = bus.E_valid && (bus.E_icode == I_OPQ) && (bus.E_ifun <= A_XOR)
                && !cc_inhibit && !M_stall;
        cc_d  = cc_q;
        if (cc_we) begin
            cc_d.zf = (val_e == '0);
            cc_d.sf = val_e[WIDTH-1];
            cc_d.of = flag_of;
        end
    end

    // Condition-code register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cc_q <= CC_RESET;
        else        cc_q <= cc_d;
    end

    // Condition from pre-edge CC; a failed cmov squashes its destination.
    always_comb begin
        cnd   = cond_eval(bus.E_ifun, cc_q);
        dst_e = ((bus.E_icode == I_RRMOVQ) && !cnd) ? RNONE : bus.E_dstE;
    end

    // E->M next state: stall holds, bubble inserts a nop, otherwise load.
    always_comb begin
        m_valid_d = m_valid_q;
        m_icode_d = m_icode_q;
        m_cnd_d   = m_cnd_q;
        m_vale_d  = m_vale_q;
        m_vala_d  = m_vala_q;
        m_dste_d  = m_dste_q;
        m_dstm_d  = m_dstm_q;
        if (!M_stall) begin
            if (M_bubble) begin
                m_valid_d = 1'b0;
                m_icode_d = I_NOP;
                m_cnd_d   = 1'b0;
                m_vale_d  = '0;
                m_vala_d  = '0;
                m_dste_d  = RNONE;
                m_dstm_d  = RNONE;
            end else begin
                m_valid_d = bus.E_valid;
                m_icode_d = bus.E_icode;
                m_cnd_d   = cnd;
                m_vale_d  = val_e;
                m_vala_d  = bus.E_valA;
                m_dste_d  = dst_e;
                m_dstm_d  = bus.E_dstM;
            end
        end
    end

    // E->M pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else begin
            m_valid_q <= m_valid_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
        end
    end

    assign bus.M_valid = m_valid_q;
    assign bus.M_icode = m_icode_q;
    assign bus.M_cnd   = m_cnd_q;
    assign bus.M_valE  = m_vale_q;
    assign bus.M_valA  = m_vala_q;
    assign bus.M_dstE  = m_dste_q;
    assign bus.M_dstM  = m_dstm_q;

    assign e_valE = val_e;
    assign e_dstE = dst_e;
    assign e_cnd  = cnd;
    assign cc_zf  = cc_q.zf;
    assign cc_sf  = cc_q.sf;
    assign cc_of  = cc_q.of;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Self-checking bench for y86_execute_stage: directed scenarios plus a
// randomized run checked against an instruction-level reference model.
module tb_y86_execute_stage;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cc_inhibit, M_stall, M_bubble;
    logic [W-1:0] e_valE;
    logic [3:0]   e_dstE;
    logic         e_cnd, cc_zf, cc_sf, cc_of;

    y86_execute_stage_if #(.WIDTH(W)) bus();

    y86_execute_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cc_inhibit (cc_inhibit),
        .M_stall    (M_stall),
        .M_bubble   (M_bubble),
        .e_valE     (e_valE),
        .e_dstE     (e_dstE),
        .e_cnd      (e_cnd),
        .cc_zf      (cc_zf),
        .cc_sf      (cc_sf),
        .cc_of      (cc_of)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // driven stimulus (bench-side copies)
    logic         t_valid, t_inh, t_stall, t_bubble;
    logic [3:0]   t_icode, t_ifun, t_dstE, t_dstM;
    logic [W-1:0] t_valA, t_valB, t_valC;

    // reference model state
    logic         r_zf, r_sf, r_of;
    logic         x_valid, x_cnd;
    logic [3:0]   x_icode, x_dstE, x_dstM;
    logic [W-1:0] x_valE, x_valA;

    // reference model combinational expectations
    logic [W-1:0] c_valE;
    logic         c_cnd, c_zf, c_sf, c_of, c_ccw;
    logic [3:0]   c_dstE;

    task automatic model_reset();
        r_zf = 1'b1; r_sf = 1'b0; r_of = 1'b0;
        x_valid = 1'b0; x_icode = 4'h1; x_cnd = 1'b0;
        x_valE = '0; x_valA = '0; x_dstE = 4'hF; x_dstM = 4'hF;
    endtask

    // Instruction semantics as written in the ISA, not as operand muxes.
    task automatic model_comb();
        logic signed [W-1:0] sa, sb, sr;
        logic lt;
        sa = $signed(t_valA);
        sb = $signed(t_valB);
        c_valE = '0;
        c_of = 1'b0;
        case (t_icode)
            4'h2: c_valE = t_valA;
            4'h3: c_valE = t_valC;
            4'h4, 4'h5: c_valE = t_valB + t_valC;
            4'h6: begin
                case (t_ifun)
                    4'h0: begin
                        c_valE = t_valB + t_valA;
                        sr = $signed(c_valE);
                        c_of = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0);
                    end
                    4'h1: begin
                        c_valE = t_valB - t_valA;
                        sr = $signed(c_valE);
                        c_of = (sb >= 0 && sa < 0 && sr < 0) || (sb < 0 && sa >= 0 && sr >= 0);
                    end
                    4'h2: c_valE = t_valB & t_valA;
                    4'h3: c_valE = t_valB ^ t_valA;
                    default: c_valE = '0;
                endcase
            end
            4'h8, 4'hA: c_valE = t_valB - 64'd8;
            4'h9, 4'hB: c_valE = t_valB + 64'd8;
            default: c_valE = '0;
        endcase
        c_zf = (c_valE == 0);
        c_sf = c_valE[W-1];
        c_ccw = t_valid && t_icode == 4'h6 && t_ifun <= 4'h3 && !t_inh && !t_stall;
        lt = (r_sf != r_of);
        case (t_ifun)
            4'h0: c_cnd = 1'b1;
            4'h1: c_cnd = lt || r_zf;
            4'h2: c_cnd = lt;
            4'h3: c_cnd = r_zf;
            4'h4: c_cnd = !r_zf;
            4'h5: c_cnd = !lt;
            4'h6: c_cnd = !lt && !r_zf;
            default: c_cnd = 1'b0;
        endcase
        c_dstE = (t_icode == 4'h2 && !c_cnd) ? 4'hF : t_dstE;
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic inh, input logic st, input logic bub);
        t_valid = v; t_icode = ic; t_ifun = fn; t_valA = a; t_valB = b; t_valC = c;
        t_dstE = de; t_dstM = dm; t_inh = inh; t_stall = st; t_bubble = bub;
        bus.E_valid = v; bus.E_icode = ic; bus.E_ifun = fn;
        bus.E_valA = a; bus.E_valB = b; bus.E_valC = c;
        bus.E_dstE = de; bus.E_dstM = dm;
        cc_inhibit = inh; M_stall = st; M_bubble = bub;
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        if (c_ccw) begin
            r_zf = c_zf; r_sf = c_sf; r_of = c_of;
        end
        if (!t_stall) begin
            if (t_bubble) begin
                x_valid = 1'b0; x_icode = 4'h1; x_cnd = 1'b0;
                x_valE = '0; x_valA = '0; x_dstE = 4'hF; x_dstM = 4'hF;
            end else begin
                x_valid = t_valid; x_icode = t_icode; x_cnd = c_cnd;
                x_valE = c_valE; x_valA = t_valA; x_dstE = c_dstE; x_dstM = t_dstM;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        model_reset();
        #10;
        n_cmp++; if ({bus.M_valid, bus.M_icode, bus.M_cnd} !== {1'b0, 4'h1, 1'b0}) begin
            n_err++; $display("FAIL reset_m_ctl: got %h expected %h", {bus.M_valid, bus.M_icode, bus.M_cnd}, {1'b0, 4'h1, 1'b0}); end
        n_cmp++; if ({bus.M_valE, bus.M_valA} !== 128'h0) begin
            n_err++; $display("FAIL reset_m_vals: got %h %h expected 0 0", bus.M_valE, bus.M_valA); end
        n_cmp++; if ({bus.M_dstE, bus.M_dstM} !== 8'hFF) begin
            n_err++; $display("FAIL reset_m_dst: got %h expected ff", {bus.M_dstE, bus.M_dstM}); end
        n_cmp++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            n_err++; $display("FAIL reset_cc: got %b expected 100", {cc_zf, cc_sf, cc_of}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, '0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_err++; $display("FAIL add_ovf_e_valE: got %h expected fffffffffffffffe", e_valE); end
        tick();
        n_cmp++; if (bus.M_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_err++; $display("FAIL add_ovf_M_valE: got %h expected fffffffffffffffe", bus.M_valE); end
        n_cmp++; if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin
            n_err++; $display("FAIL add_ovf_cc: got %b expected 011", {cc_zf, cc_sf, cc_of}); end
        // 0x7FFF..F + 1 wraps to 0x8000..0 with overflow
        drive(1'b1, 4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, '0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if ({bus.M_valE, cc_zf, cc_sf, cc_of} !== {64'h8000_0000_0000_0000, 3'b011}) begin
            n_err++; $display("FAIL add_wrap: got %h %b expected 8000000000000000 011", bus.M_valE, {cc_zf, cc_sf, cc_of}); end
    endtask

    task automatic test_sub_jxx();
        drive(1'b1, 4'h6, 4'h1, 64'h1, 64'h1, '0, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (e_valE !== 64'h0) begin
            n_err++; $display("FAIL sub_e_valE: got %h expected 0", e_valE); end
        tick();
        n_cmp++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            n_err++; $display("FAIL sub_cc: got %b expected 100", {cc_zf, cc_sf, cc_of}); end
        drive(1'b1, 4'h7, 4'h3, '0, '0, 64'h40, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (e_cnd !== 1'b1) begin
            n_err++; $display("FAIL jxx_e: got %b expected 1", e_cnd); end
        drive(1'b1, 4'h7, 4'h4, '0, '0, 64'h40, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (e_cnd !== 1'b0) begin
            n_err++; $display("FAIL jxx_ne: got %b expected 0", e_cnd); end
        tick();
        n_cmp++; if ({bus.M_icode, bus.M_cnd} !== {4'h7, 1'b0}) begin
            n_err++; $display("FAIL jxx_M: got %h expected 70", {bus.M_icode, bus.M_cnd}); end
    endtask

    task automatic test_cmov();
        drive(1'b1, 4'h6, 4'h0, 64'h1, 64'h1, '0, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'h2, 4'h2, 64'h55, '0, '0, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0);
        n_cmp++; if ({e_cnd, e_dstE} !== {1'b0, 4'hF}) begin
            n_err++; $display("FAIL cmov_l_false: got %b %h expected 0 f", e_cnd, e_dstE); end
        tick();
        n_cmp++; if (bus.M_dstE !== 4'hF) begin
            n_err++; $display("FAIL cmov_squash_M: got %h expected f", bus.M_dstE); end
        // 1 - 5 is negative without overflow: SF=1, OF=0
        drive(1'b1, 4'h6, 4'h1, 64'h5, 64'h1, '0, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'h2, 4'h2, 64'h55, '0, '0, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0);
        n_cmp++; if ({e_cnd, e_dstE, e_valE} !== {1'b1, 4'h5, 64'h55}) begin
            n_err++; $display("FAIL cmov_l_true: got %b %h %h expected 1 5 55", e_cnd, e_dstE, e_valE); end
        tick();
        n_cmp++; if ({bus.M_cnd, bus.M_dstE} !== {1'b1, 4'h5}) begin
            n_err++; $display("FAIL cmov_pass_M: got %b %h expected 1 5", bus.M_cnd, bus.M_dstE); end
    endtask

    task automatic test_inhibit_stall_bubble();
        drive(1'b1, 4'h6, 4'h1, 64'h7, 64'h7, '0, 4'h4, 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        n_cmp++; if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin
            n_err++; $display("FAIL inhibit_cc: got %b expected 010", {cc_zf, cc_sf, cc_of}); end
        n_cmp++; if ({bus.M_valid, bus.M_valE, bus.M_dstE} !== {1'b1, 64'h0, 4'h4}) begin
            n_err++; $display("FAIL inhibit_M_load: got %b %h %h expected 1 0 4", bus.M_valid, bus.M_valE, bus.M_dstE); end
        drive(1'b1, 4'h6, 4'h1, 64'h9, 64'h9, '0, 4'h6, 4'h3, 1'b0, 1'b1, 1'b1);
        tick();
        n_cmp++; if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin
            n_err++; $display("FAIL stall_cc: got %b expected 010", {cc_zf, cc_sf, cc_of}); end
        n_cmp++; if ({bus.M_valid, bus.M_dstE, bus.M_dstM, bus.M_valA} !== {1'b1, 4'h4, 4'hF, 64'h7}) begin
            n_err++; $display("FAIL stall_hold: got %b %h %h %h expected 1 4 f 7", bus.M_valid, bus.M_dstE, bus.M_dstM, bus.M_valA); end
        drive(1'b1, 4'h6, 4'h0, 64'h3, 64'h4, '0, 4'h2, 4'hF, 1'b0, 1'b0, 1'b1);
        tick();
        n_cmp++; if ({bus.M_valid, bus.M_icode, bus.M_dstE, bus.M_valE} !== {1'b0, 4'h1, 4'hF, 64'h0}) begin
            n_err++; $display("FAIL bubble_nop: got %b %h %h %h expected 0 1 f 0", bus.M_valid, bus.M_icode, bus.M_dstE, bus.M_valE); end
        n_cmp++; if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin
            n_err++; $display("FAIL bubble_cc_write: got %b expected 000", {cc_zf, cc_sf, cc_of}); end
    endtask

    task automatic test_push_pop();
        drive(1'b1, 4'hA, 4'h0, 64'h1234, 64'h100, '0, 4'h4, 4'hF, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (e_valE !== 64'hF8) begin
            n_err++; $display("FAIL push_e_valE: got %h expected f8", e_valE); end
        tick();
        n_cmp++; if ({bus.M_valE, cc_zf, cc_sf, cc_of} !== {64'hF8, 3'b000}) begin
            n_err++; $display("FAIL push_M: got %h %b expected f8 000", bus.M_valE, {cc_zf, cc_sf, cc_of}); end
        drive(1'b1, 4'hB, 4'h0, 64'h0, 64'h100, '0, 4'h4, 4'h6, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (e_valE !== 64'h108) begin
            n_err++; $display("FAIL pop_e_valE: got %h expected 108", e_valE); end
        tick();
        n_cmp++; if ({bus.M_valE, bus.M_dstM, cc_zf, cc_sf, cc_of} !== {64'h108, 4'h6, 3'b000}) begin
            n_err++; $display("FAIL pop_M: got %h %h %b expected 108 6 000", bus.M_valE, bus.M_dstM, {cc_zf, cc_sf, cc_of}); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, c;
        for (int i = 0; i < 300; i++) begin
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = {1'b0, b[W-2:0]};
            c = {$urandom, $urandom};
            drive(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 7)),
                  a, b, c, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            n_cmp++; if ({e_valE, e_dstE, e_cnd} !== {c_valE, c_dstE, c_cnd}) begin
                n_err++; $display("FAIL rand_fwd[%0d]: got %h %h %b expected %h %h %b", i, e_valE, e_dstE, e_cnd, c_valE, c_dstE, c_cnd); end
            tick();
            n_cmp++; if ({cc_zf, cc_sf, cc_of} !== {r_zf, r_sf, r_of}) begin
                n_err++; $display("FAIL rand_cc[%0d]: got %b expected %b", i, {cc_zf, cc_sf, cc_of}, {r_zf, r_sf, r_of}); end
            n_cmp++; if ({bus.M_valid, bus.M_icode, bus.M_cnd, bus.M_dstE, bus.M_dstM} !== {x_valid, x_icode, x_cnd, x_dstE, x_dstM}) begin
                n_err++; $display("FAIL rand_M_ctl[%0d]: got %h expected %h", i,
                    {bus.M_valid, bus.M_icode, bus.M_cnd, bus.M_dstE, bus.M_dstM}, {x_valid, x_icode, x_cnd, x_dstE, x_dstM}); end
            n_cmp++; if ({bus.M_valE, bus.M_valA} !== {x_valE, x_valA}) begin
                n_err++; $display("FAIL rand_M_vals[%0d]: got %h %h expected %h %h", i, bus.M_valE, bus.M_valA, x_valE, x_valA); end
        end
    endtask

    task automatic test_reset_midrun();
        drive(1'b1, 4'h6, 4'h1, 64'h3, 64'h1, '0, 4'h2, 4'h4, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if ({bus.M_valid, cc_sf} !== 2'b11) begin
            n_err++; $display("FAIL pre_reset_state: got %b expected 11", {bus.M_valid, cc_sf}); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.M_valid, bus.M_icode, cc_zf, cc_sf, cc_of} !== {1'b0, 4'h1, 3'b100}) begin
            n_err++; $display("FAIL async_reset: got %h expected %h", {bus.M_valid, bus.M_icode, cc_zf, cc_sf, cc_of}, {1'b0, 4'h1, 3'b100}); end
        n_cmp++; if ({bus.M_valE, bus.M_dstE} !== {64'h0, 4'hF}) begin
            n_err++; $display("FAIL async_reset_vals: got %h %h expected 0 f", bus.M_valE, bus.M_dstE); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_jxx();
        test_cmov();
        test_inhibit_stall_bubble();
        test_push_pop();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
